// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - three-source writeback arbiter onto two register-file write ports
// Keeps age order through an in-order overflow FIFO and exports a busy vector.
module wb_arbiter #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s0_valid,
    input  logic              s1_valid,
    input  logic              s2_valid,
    output logic              s0_ready,
    output logic              s1_ready,
    output logic              s2_ready,
    input  logic [ADDR_W-1:0] s0_addr,
    input  logic [ADDR_W-1:0] s1_addr,
    input  logic [ADDR_W-1:0] s2_addr,
    input  logic [DATA_W-1:0] s0_data,
    input  logic [DATA_W-1:0] s1_data,
    input  logic [DATA_W-1:0] s2_data,
    output logic              we1,
    output logic              we2,
    output logic [ADDR_W-1:0] waddr1,
    output logic [ADDR_W-1:0] waddr2,
    output logic [DATA_W-1:0] wdata1,
    output logic [DATA_W-1:0] wdata2,
    output logic [31:0]       busy,
    output logic [3:0]        count
);
    // Ordered view: FIFO entries first, then this cycle's arrivals; at most DEPTH live slots.
    localparam int SEQ_N = DEPTH + 2;

    logic [ADDR_W-1:0] r_fifo_addr [DEPTH];
    logic [DATA_W-1:0] r_fifo_data [DEPTH];
    logic [3:0]        r_count;
    logic              r_we1;
    logic              r_we2;
    logic [ADDR_W-1:0] r_waddr1;
    logic [ADDR_W-1:0] r_waddr2;
    logic [DATA_W-1:0] r_wdata1;
    logic [DATA_W-1:0] r_wdata2;

    logic              w_ready;
    logic [2:0]        w_take;
    logic [ADDR_W-1:0] w_src_addr [3];
    logic [DATA_W-1:0] w_src_data [3];
    logic [3:0]        w_pos [3];
    logic [3:0]        w_n;
    logic [1:0]        w_k;
    logic [ADDR_W-1:0] w_seq_addr [SEQ_N];
    logic [DATA_W-1:0] w_seq_data [SEQ_N];
    logic [31:0]       w_busy;

    assign w_src_addr[0] = s0_addr;
    assign w_src_addr[1] = s1_addr;
    assign w_src_addr[2] = s2_addr;
    assign w_src_data[0] = s0_data;
    assign w_src_data[1] = s1_data;
    assign w_src_data[2] = s2_data;

    assign w_ready  = rst && (r_count <= 4'(DEPTH - 3));
    assign s0_ready = w_ready;
    assign s1_ready = w_ready;
    assign s2_ready = w_ready;

    // Writes to x0 are accepted but never take a slot.
    assign w_take[0] = s0_valid && w_ready && (s0_addr != '0);
    assign w_take[1] = s1_valid && w_ready && (s1_addr != '0);
    assign w_take[2] = s2_valid && w_ready && (s2_addr != '0);

    assign w_pos[0] = r_count;
    assign w_pos[1] = w_pos[0] + {3'b000, w_take[0]};
    assign w_pos[2] = w_pos[1] + {3'b000, w_take[1]};
    assign w_n      = w_pos[2] + {3'b000, w_take[2]};

    always_comb begin
        for (int j = 0; j < SEQ_N; j++) begin
            w_seq_addr[j] = '0;
            w_seq_data[j] = '0;
        end
        for (int j = 0; j < DEPTH; j++) begin
            if (4'(j) < r_count) begin
                w_seq_addr[j] = r_fifo_addr[j];
                w_seq_data[j] = r_fifo_data[j];
            end
        end
        for (int j = 0; j < SEQ_N; j++) begin
            for (int s = 0; s < 3; s++) begin
                if (w_take[s] && (w_pos[s] == 4'(j))) begin
                    w_seq_addr[j] = w_src_addr[s];
                    w_seq_data[j] = w_src_data[s];
                end
            end
        end
    end

    // Same-address pair: hold back the younger one so WAW order survives.
    always_comb begin
        w_k = 2'd0;
        if (w_n == 4'd1) begin
            w_k = 2'd1;
        end else if (w_n >= 4'd2) begin
            w_k = (w_seq_addr[0] != w_seq_addr[1]) ? 2'd2 : 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count  <= '0;
            r_we1    <= 1'b0;
            r_we2    <= 1'b0;
            r_waddr1 <= '0;
            r_waddr2 <= '0;
            r_wdata1 <= '0;
            r_wdata2 <= '0;
            for (int j = 0; j < DEPTH; j++) begin
                r_fifo_addr[j] <= '0;
                r_fifo_data[j] <= '0;
            end
        end else begin
            r_we1    <= (w_k != 2'd0);
            r_waddr1 <= (w_k != 2'd0) ? w_seq_addr[0] : '0;
            r_wdata1 <= (w_k != 2'd0) ? w_seq_data[0] : '0;
            r_we2    <= (w_k == 2'd2);
            r_waddr2 <= (w_k == 2'd2) ? w_seq_addr[1] : '0;
            r_wdata2 <= (w_k == 2'd2) ? w_seq_data[1] : '0;
            r_count  <= w_n - {2'b00, w_k};
            for (int j = 0; j < DEPTH; j++) begin
                case (w_k)
                    2'd0: begin
                        r_fifo_addr[j] <= w_seq_addr[j];
                        r_fifo_data[j] <= w_seq_data[j];
                    end
                    2'd1: begin
                        r_fifo_addr[j] <= w_seq_addr[j+1];
                        r_fifo_data[j] <= w_seq_data[j+1];
                    end
                    default: begin
                        r_fifo_addr[j] <= w_seq_addr[j+2];
                        r_fifo_data[j] <= w_seq_data[j+2];
                    end
                endcase
            end
        end
    end

    always_comb begin
        w_busy = '0;
        for (int j = 0; j < DEPTH; j++) begin
            if (4'(j) < r_count) begin
                w_busy = w_busy | (32'd1 << r_fifo_addr[j]);
            end
        end
        if (r_we1) begin
            w_busy = w_busy | (32'd1 << r_waddr1);
        end
        if (r_we2) begin
            w_busy = w_busy | (32'd1 << r_waddr2);
        end
    end

    assign we1    = r_we1;
    assign we2    = r_we2;
    assign waddr1 = r_waddr1;
    assign waddr2 = r_waddr2;
    assign wdata1 = r_wdata1;
    assign wdata2 = r_wdata2;
    assign busy   = w_busy;
    assign count  = r_count;
endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - scoreboard bench for wb_arbiter against a queue-based age-order model
module tb_wb_arbiter;
    localparam int DEPTH = 4;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } ent_t;

    typedef struct {
        logic        we1;
        logic [4:0]  a1;
        logic [31:0] d1;
        logic        we2;
        logic [4:0]  a2;
        logic [31:0] d2;
        logic [3:0]  cnt;
        logic [31:0] busy;
        logic        rdy;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  s_valid;
    wire  [2:0]  s_ready;
    logic [4:0]  s_addr [3];
    logic [31:0] s_data [3];
    wire         we1, we2;
    wire  [4:0]  waddr1, waddr2;
    wire  [31:0] wdata1, wdata2;
    wire  [31:0] busy;
    wire  [3:0]  count;

    ent_t        pend [$];
    exp_t        expq [$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] rf [32];

    logic [2:0]  cur_v;
    logic [4:0]  cur_a [3];
    logic [31:0] cur_d [3];
    logic [2:0]  fired;

    always #5 clk = ~clk;

    wb_arbiter #(.DEPTH(DEPTH), .ADDR_W(5), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .s0_valid(s_valid[0]), .s1_valid(s_valid[1]), .s2_valid(s_valid[2]),
        .s0_ready(s_ready[0]), .s1_ready(s_ready[1]), .s2_ready(s_ready[2]),
        .s0_addr(s_addr[0]), .s1_addr(s_addr[1]), .s2_addr(s_addr[2]),
        .s0_data(s_data[0]), .s1_data(s_data[1]), .s2_data(s_data[2]),
        .we1(we1), .we2(we2), .waddr1(waddr1), .waddr2(waddr2),
        .wdata1(wdata1), .wdata2(wdata2), .busy(busy), .count(count)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
        end
    endtask

    // One clock of stimulus; the model predicts the DUT state after the coming edge.
    task automatic drive(input logic r, input logic [2:0] v,
                         input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2,
                         input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                         output logic [2:0] f);
        exp_t        e;
        ent_t        x;
        ent_t        y;
        logic        rdy;
        logic [4:0]  aa [3];
        logic [31:0] dd [3];
        aa[0] = a0; aa[1] = a1; aa[2] = a2;
        dd[0] = d0; dd[1] = d1; dd[2] = d2;
        @(negedge clk);
        rst = r;
        s_valid = v;
        for (int s = 0; s < 3; s++) begin
            s_addr[s] = aa[s];
            s_data[s] = dd[s];
        end
        e = '{default: '0};
        f = 3'b000;
        if (!r) begin
            pend.delete();
        end else begin
            rdy = (pend.size() <= DEPTH - 3);
            for (int s = 0; s < 3; s++) begin
                if (v[s] && rdy) begin
                    f[s] = 1'b1;
                    if (aa[s] != 5'd0) begin
                        x.addr = aa[s];
                        x.data = dd[s];
                        pend.push_back(x);
                    end
                end
            end
            if (pend.size() > 0) begin
                x = pend.pop_front();
                e.we1 = 1'b1; e.a1 = x.addr; e.d1 = x.data;
                if (pend.size() > 0 && pend[0].addr != x.addr) begin
                    y = pend.pop_front();
                    e.we2 = 1'b1; e.a2 = y.addr; e.d2 = y.data;
                end
            end
            e.cnt = 4'(pend.size());
            foreach (pend[i]) e.busy[pend[i].addr] = 1'b1;
            if (e.we1) e.busy[e.a1] = 1'b1;
            if (e.we2) e.busy[e.a2] = 1'b1;
            e.rdy = (pend.size() <= DEPTH - 3);
        end
        expq.push_back(e);
    endtask

    task automatic idle(input int n);
        logic [2:0] f;
        for (int i = 0; i < n; i++) drive(1'b1, 3'b000, 0, 0, 0, 0, 0, 0, f);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("port1", 64'({we1, waddr1, wdata1}), 64'({e.we1, e.a1, e.d1}));
                chk("port2", 64'({we2, waddr2, wdata2}), 64'({e.we2, e.a2, e.d2}));
                chk("count", 64'(count), 64'(e.cnt));
                chk("busy", 64'(busy), 64'(e.busy));
                chk("ready", 64'(s_ready), 64'({3{e.rdy}}));
                if (we1) rf[waddr1] = wdata1;
                if (we2) rf[waddr2] = wdata2;
            end
        end
    end

    initial begin
        rst = 1'b0;
        s_valid = 3'b000;
        for (int s = 0; s < 3; s++) begin
            s_addr[s] = '0;
            s_data[s] = '0;
        end
        drive(1'b0, 3'b000, 0, 0, 0, 0, 0, 0, fired);
        drive(1'b0, 3'b000, 0, 0, 0, 0, 0, 0, fired);

        drive(1'b1, 3'b001, 5, 0, 0, 32'h11, 0, 0, fired);
        idle(2);
        drive(1'b1, 3'b111, 1, 2, 3, 32'hA, 32'hB, 32'hC, fired);
        idle(3);
        drive(1'b1, 3'b011, 7, 7, 0, 32'h1, 32'h2, 0, fired);
        idle(3);
        @(posedge clk);
        #2;
        chk("rf_x7", 64'(rf[7]), 64'h2);
        drive(1'b1, 3'b011, 4, 0, 0, 32'h9, 32'hDEAD, 0, fired);
        idle(2);

        drive(1'b1, 3'b111, 10, 11, 12, 32'h100, 32'h101, 32'h102, fired);
        drive(1'b1, 3'b111, 13, 14, 15, 32'h103, 32'h104, 32'h105, fired);
        drive(1'b0, 3'b000, 0, 0, 0, 0, 0, 0, fired);
        idle(4);

        // All sources saturated, holding unaccepted requests stable.
        cur_v = 3'b000;
        for (int c = 0; c < 100; c++) begin
            for (int s = 0; s < 3; s++) begin
                if (!cur_v[s] || fired[s]) begin
                    cur_v[s] = 1'b1;
                    cur_a[s] = 5'($urandom_range(1, 7));
                    cur_d[s] = $urandom;
                end
            end
            drive(1'b1, cur_v, cur_a[0], cur_a[1], cur_a[2], cur_d[0], cur_d[1], cur_d[2], fired);
        end

        for (int c = 0; c < 600; c++) begin
            for (int s = 0; s < 3; s++) begin
                if (!cur_v[s] || fired[s]) begin
                    cur_v[s] = ($urandom_range(0, 3) != 0);
                    cur_a[s] = 5'($urandom_range(0, 9));
                    cur_d[s] = $urandom;
                end
            end
            drive(($urandom_range(0, 49) != 0), cur_v, cur_a[0], cur_a[1], cur_a[2],
                  cur_d[0], cur_d[1], cur_d[2], fired);
        end

        idle(8);
        @(posedge clk);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
